// File: rtl/mul_sequencer.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier sequencer.
// Borrows the datapath adder; owns only the operand/partial registers.
module mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     addA,
    output logic [WIDTH-1:0]     addB,
    output logic                 addInC,
    input  logic [WIDTH-1:0]     addSum,
    input  logic                 addOutC
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             lastStep;
    logic [2*WIDTH-1:0] stepVal;

    // Carry lands in the top of ACC, so the shifted pair never loses a bit.
    assign stepVal  = {addOutC, addSum, mq[WIDTH-1:1]};
    assign lastStep = (cnt == CW'(WIDTH - 1));

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        addA      = '0;
        addB      = '0;
        addInC    = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                addA = acc;
                addB = mq[0] ? m : '0;
                if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                m   <= mcand;
                acc <= '0;
                mq  <= mplier;
                cnt <= '0;
            end else if (state == RUN) begin
                {acc, mq} <= stepVal;
                cnt       <= cnt + CW'(1);
                if (lastStep) begin
                    product <= stepVal;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with a behavioural 8-bit adder.
// Expected products are pushed at issue time and popped on each done.
module tb_mul_sequencer;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  addA;
    logic [7:0]  addB;
    logic        addInC;
    logic [7:0]  addSum;
    logic        addOutC;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] expQ[$];
    logic [7:0]  bSeq[$];
    logic        anyInC;

    mul_sequencer #(.WIDTH(8)) dut (
        .clk     (clk),
        .rstN    (rstN),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .addA    (addA),
        .addB    (addB),
        .addInC  (addInC),
        .addSum  (addSum),
        .addOutC (addOutC)
    );

    // Adder in add mode; inC would add 1 if the DUT ever drove it.
    assign {addOutC, addSum} = {1'b0, addA} + {1'b0, addB} + {8'd0, addInC};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got product %0h expected no done",
                         product);
            end else begin
                logic [15:0] e;
                e = expQ.pop_front();
                if (product !== e) begin
                    mismatched++;
                    $display("FAIL product: got %0h expected %0h", product, e);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
        mcand  = 8'h5C;
        mplier = 8'hC5;
    endtask

    task automatic runToDone(output int busyCyc, output int doneAt);
        busyCyc = 0;
        doneAt  = 0;
        anyInC  = 1'b0;
        bSeq.delete();
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                doneAt = i;
                break;
            end
            if (busy) begin
                busyCyc++;
                bSeq.push_back(addB);
            end
            anyInC = anyInC | addInC;
            @(negedge clk);
        end
        if (doneAt == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done expected done within 30");
        end
    endtask

    int bc;
    int da;
    logic [7:0] expB[8];

    initial begin
        rstN   = 1'b0;
        start  = 1'b1;
        mcand  = 8'hFF;
        mplier = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        check("rst_addA", 32'(addA), 0);
        check("rst_addB", 32'(addB), 0);
        start = 1'b0;
        rstN  = 1'b1;
        @(negedge clk);

        // 1: FF*FF, full-cycle timing
        expQ.push_back(16'hFE01);
        issue(8'hFF, 8'hFF);
        runToDone(bc, da);
        check("t1_busy_cycles", 32'(bc), 8);
        check("t1_done_cycle", 32'(da), 9);
        @(negedge clk);
        check("t1_idle_after", 32'(busy | done), 0);

        // 2: 0D*0B with addB probe
        expQ.push_back(16'h008F);
        issue(8'h0D, 8'h0B);
        runToDone(bc, da);
        expB = '{8'h0D, 8'h0D, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
        check("t2_bseq_len", 32'(bSeq.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < bSeq.size()) begin
                check($sformatf("t2_addB[%0d]", i), 32'(bSeq[i]), 32'(expB[i]));
            end
        end
        @(negedge clk);

        // 3: zero multiplicand still takes full time
        expQ.push_back(16'h0000);
        issue(8'h00, 8'h5A);
        runToDone(bc, da);
        check("t3_done_cycle", 32'(da), 9);
        check("t3_addInC", 32'(anyInC), 0);
        @(negedge clk);

        // 4: start mid-RUN is ignored
        expQ.push_back(16'h000C);
        issue(8'h03, 8'h04);
        repeat (2) @(negedge clk);
        start  = 1'b1;
        mcand  = 8'h10;
        mplier = 8'h10;
        @(negedge clk);
        start = 1'b0;
        runToDone(bc, da);
        check("t4_done_seen", 32'(da != 0), 1);
        repeat (12) @(negedge clk);
        check("t4_no_rerun", 32'(busy), 0);

        // 5: back-to-back start in DONE cycle
        expQ.push_back(16'h000A);
        issue(8'h02, 8'h05);
        runToDone(bc, da);
        expQ.push_back(16'h0100);
        start  = 1'b1;
        mcand  = 8'h80;
        mplier = 8'h02;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy_next", 32'(busy), 1);
        check("t5_product_held", 32'(product), 32'h000A);
        runToDone(bc, da);
        check("t5_done_cycle", 32'(da), 9);
        @(negedge clk);

        // 6: reset on 4th RUN cycle aborts
        issue(8'hAA, 8'h55);
        repeat (3) @(negedge clk);
        check("t6_busy_before_rst", 32'(busy), 1);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check("t6_product", 32'(product), 0);
        repeat (12) @(negedge clk);
        expQ.push_back(16'h003F);
        issue(8'h07, 8'h09);
        runToDone(bc, da);
        check("t6_restart_cycle", 32'(da), 9);
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(expQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
